led_write_arbiter: RTL and testbench

- Shares the LED peripheral's write port (low byte at LEDBaseAddr, high byte at LEDBaseAddr+1) between two requesters.
  - M0: processor-side write path.
  - M1: auxiliary hardware master, e.g. a status or timer engine.
- Round-robin arbitration, valid/ready handshakes and a bounded lock for M1 bursts.
- Drives one registered write per cycle onto the LED peripheral's BUS_ADDR/BUS_DATA/BUS_WE inputs.

---
 rtl/led_write_arbiter.sv | 83 ++++++++
 tb/tb_led_write_arbiter.sv | 101 ++++++++++
 2 files changed

// File: rtl/led_write_arbiter.sv
// led_write_arbiter: round-robin arbiter with bounded M1 lock, sharing the LED write port between two masters
module led_write_arbiter #(
  parameter logic [7:0] LEDBaseAddr = 8'hC0,
  parameter int LOCK_MAX = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       M0_VALID,
  input  logic [7:0] M0_ADDR,
  input  logic [7:0] M0_DATA,
  output logic       M0_READY,
  input  logic       M1_VALID,
  input  logic [7:0] M1_ADDR,
  input  logic [7:0] M1_DATA,
  input  logic       M1_LOCK,
  output logic       M1_READY,
  output logic [7:0] BUS_ADDR,
  output logic [7:0] BUS_DATA,
  output logic       BUS_WE,
  output logic [7:0] DROP_CNT
);
  typedef enum logic [1:0] {IDLE, SERVE, LOCK1} state_t;
  localparam logic [7:0] HI_ADDR = LEDBaseAddr + 8'd1;
  localparam logic [3:0] LMAX = 4'(LOCK_MAX);
  state_t state, state_nx;
  logic last, last_nx;
  logic [3:0] cnt, cnt_nx;
  logic locked, g0, g1, acc, in_win;
  logic [7:0] sel_addr, sel_data;
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      state <= IDLE;
      last <= 1'b1;
      cnt <= '0;
    end else begin
      state <= state_nx;
      last <= last_nx;
      cnt <= cnt_nx;
    end
  always_comb begin
    state_nx = IDLE;
    last_nx = last;
    cnt_nx = '0;
    if (locked) begin
      cnt_nx = cnt + 4'd1;
      state_nx = cnt_nx == LMAX ? SERVE : LOCK1;
      last_nx = 1'b1;
    end else if (g1 && M1_LOCK) begin
      cnt_nx = 4'd1;
      state_nx = LMAX == 4'd1 ? SERVE : LOCK1;
      last_nx = 1'b1;
    end else if (g0 || g1) begin
      state_nx = SERVE;
      last_nx = g1;
    end
  end
  // outside a held lock, LAST is already 1 after any M1 grant, so an unlocked LOCK1 arbitrates like SERVE
  always_comb begin
    locked = state == LOCK1 && M1_VALID && M1_LOCK;
    g1 = locked || (M1_VALID && (!M0_VALID || !last));
    g0 = M0_VALID && !g1;
    M0_READY = g0;
    M1_READY = g1;
    acc = g0 || g1;
    sel_addr = g1 ? M1_ADDR : M0_ADDR;
    sel_data = g1 ? M1_DATA : M0_DATA;
    in_win = sel_addr == LEDBaseAddr || sel_addr == HI_ADDR;
  end
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      BUS_ADDR <= '0;
      BUS_DATA <= '0;
      BUS_WE <= 1'b0;
      DROP_CNT <= '0;
    end else begin
      BUS_WE <= acc && in_win;
      if (acc && in_win) begin
        BUS_ADDR <= sel_addr;
        BUS_DATA <= sel_data;
      end
      if (acc && !in_win && DROP_CNT != 8'hFF) DROP_CNT <= DROP_CNT + 8'd1;
    end
endmodule

// File: tb/tb_led_write_arbiter.sv
// tb_led_write_arbiter: directed vectors with hand-computed grants, strobes and drop counts
module tb_led_write_arbiter;
  logic CLK, RESET;
  logic M0_VALID, M0_READY, M1_VALID, M1_LOCK, M1_READY, BUS_WE;
  logic [7:0] M0_ADDR, M0_DATA, M1_ADDR, M1_DATA, BUS_ADDR, BUS_DATA, DROP_CNT;
  int errors = 0;
  int checks = 0;
  led_write_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .M0_VALID(M0_VALID), .M0_ADDR(M0_ADDR), .M0_DATA(M0_DATA), .M0_READY(M0_READY),
    .M1_VALID(M1_VALID), .M1_ADDR(M1_ADDR), .M1_DATA(M1_DATA), .M1_LOCK(M1_LOCK), .M1_READY(M1_READY),
    .BUS_ADDR(BUS_ADDR), .BUS_DATA(BUS_DATA), .BUS_WE(BUS_WE), .DROP_CNT(DROP_CNT)
  );
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // one bus cycle: drive, check READYs mid-cycle, then check the registered strobe after the edge
  task automatic cyc(input logic v0, input logic [7:0] a0, input logic [7:0] d0,
                     input logic v1, input logic [7:0] a1, input logic [7:0] d1, input logic lk,
                     input logic e0, input logic e1, input logic ew, input string tag);
    M0_VALID = v0; M0_ADDR = a0; M0_DATA = d0;
    M1_VALID = v1; M1_ADDR = a1; M1_DATA = d1; M1_LOCK = lk;
    #1;
    check({tag, ".r0"}, 32'(M0_READY), 32'(e0));
    check({tag, ".r1"}, 32'(M1_READY), 32'(e1));
    @(posedge CLK); #1;
    check({tag, ".we"}, 32'(BUS_WE), 32'(ew));
    if (ew) begin
      check({tag, ".addr"}, 32'(BUS_ADDR), 32'(e1 ? a1 : a0));
      check({tag, ".data"}, 32'(BUS_DATA), 32'(e1 ? d1 : d0));
    end
  endtask
  task automatic idle(input string tag);
    cyc(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 0, tag);
  endtask
  initial begin
    RESET = 1'b0;
    M0_VALID = 0; M0_ADDR = 0; M0_DATA = 0;
    M1_VALID = 0; M1_ADDR = 0; M1_DATA = 0; M1_LOCK = 0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst.we", 32'(BUS_WE), 0);
    check("rst.addr", 32'(BUS_ADDR), 0);
    check("rst.data", 32'(BUS_DATA), 0);
    check("rst.drop", 32'(DROP_CNT), 0);
    RESET = 1'b1;
    cyc(1, 8'hC0, 8'h11, 1, 8'hC1, 8'h22, 0, 1, 0, 1, "tie0");
    cyc(0, 8'h00, 8'h00, 1, 8'hC1, 8'h22, 0, 0, 1, 1, "tie1");
    for (int i = 0; i < 8; i++)
      cyc(1, 8'hC0, 8'(8'h30 + i), 1, 8'hC1, 8'(8'h40 + i), 0, !i[0], i[0], 1, $sformatf("fair%0d", i));
    cyc(1, 8'hC0, 8'hA5, 0, 8'h00, 8'h00, 0, 1, 0, 1, "single");
    idle("single.after");
    check("hold.addr", 32'(BUS_ADDR), 32'h0C0);
    check("hold.data", 32'(BUS_DATA), 32'h0A5);
    for (int i = 0; i < 4; i++)
      cyc(1, 8'hC0, 8'h50, 1, 8'hC1, 8'(8'h60 + i), 1, 0, 1, 1, $sformatf("lock%0d", i));
    cyc(1, 8'hC0, 8'h50, 1, 8'hC1, 8'h70, 1, 1, 0, 1, "lock.m0");
    cyc(1, 8'hC0, 8'h51, 1, 8'hC1, 8'h70, 1, 0, 1, 1, "unlk0");
    cyc(1, 8'hC0, 8'h51, 1, 8'hC0, 8'h71, 1, 0, 1, 1, "unlk1");
    cyc(1, 8'hC0, 8'h51, 1, 8'hC1, 8'h72, 0, 1, 0, 1, "unlk.m0");
    cyc(0, 8'h00, 8'h00, 1, 8'hC1, 8'h72, 0, 0, 1, 1, "unlk.m1");
    check("drop.pre", 32'(DROP_CNT), 0);
    cyc(0, 8'h00, 8'h00, 1, 8'h10, 8'h99, 0, 0, 1, 0, "drop1");
    check("drop.cnt1", 32'(DROP_CNT), 1);
    cyc(1, 8'hC2, 8'h98, 0, 8'h00, 8'h00, 0, 1, 0, 0, "drop2");
    check("drop.cnt2", 32'(DROP_CNT), 2);
    check("drop.hold", 32'(BUS_DATA), 32'h072);
    M0_VALID = 1; M0_ADDR = 8'hC1; M0_DATA = 8'hEE;
    @(posedge CLK); #1;
    M0_VALID = 0;
    check("mid.we", 32'(BUS_WE), 1);
    RESET = 1'b0;
    #1;
    check("mid.rst.we", 32'(BUS_WE), 0);
    check("mid.rst.addr", 32'(BUS_ADDR), 0);
    check("mid.rst.data", 32'(BUS_DATA), 0);
    check("mid.rst.drop", 32'(DROP_CNT), 0);
    @(posedge CLK); #1;
    RESET = 1'b1;
    check("mid.rst.hold", 32'(BUS_WE), 0);
    cyc(1, 8'hC0, 8'h81, 1, 8'hC1, 8'h82, 0, 1, 0, 1, "rtie0");
    cyc(0, 8'h00, 8'h00, 1, 8'hC1, 8'h82, 0, 0, 1, 1, "rtie1");
    M1_VALID = 1; M1_ADDR = 8'h10; M1_DATA = 8'h00; M1_LOCK = 0;
    repeat (254) @(posedge CLK);
    #1;
    check("sat.fe", 32'(DROP_CNT), 32'h0FE);
    repeat (46) @(posedge CLK);
    #1;
    M1_VALID = 0;
    check("sat.ff", 32'(DROP_CNT), 32'h0FF);
    check("sat.we", 32'(BUS_WE), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
